// File: rtl/hazard_unit.sv
// ID-side stall/flush controller for the 5-stage MIPS pipeline.
// Optional multi-cycle mult/div tracking enabled by HAZARD_MULDIV_EN.
module hazard_unit #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ID_Rs,
    input  logic [4:0] ID_Rt,
    input  logic       ID_UsesRs,
    input  logic       ID_UsesRt,
    input  logic       ID_MulDiv,
    input  logic       ID_ReadsHiLo,
    input  logic       ID_EX_MemRead,
    input  logic [4:0] ID_EX_Rt,
    input  logic       EX_BranchTaken,
    output logic       PCWrite,
    output logic       IF_ID_Write,
    output logic       IF_ID_Flush,
    output logic       ID_EX_Bubble,
    output logic       MD_Start,
    output logic       MD_Busy,
    output logic       MD_Done
);

    logic load_use;
    logic md_haz;
    logic stall;

    always_comb begin
        load_use = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                   ((ID_UsesRs && (ID_Rs == ID_EX_Rt)) ||
                    (ID_UsesRt && (ID_Rt == ID_EX_Rt)));
    end

`ifdef HAZARD_MULDIV_EN
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             md_start;

    assign md_haz   = (state_q == BUSY) && (ID_MulDiv || ID_ReadsHiLo);
    assign md_start = ID_MulDiv && !stall && !EX_BranchTaken;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (md_start) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(MD_LATENCY - 1);
                end
            end
            BUSY: begin
                // A second mult/div while busy is stalled, so no restart here.
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign MD_Start = md_start;
    assign MD_Busy  = (state_q == BUSY);
    assign MD_Done  = done_q;
`else
    logic             unused_in;
    logic [CNT_W-1:0] unused_cnt;

    assign unused_in  = ^{clk, rst, ID_MulDiv, ID_ReadsHiLo};
    assign unused_cnt = CNT_W'(MD_LATENCY);

    assign md_haz   = 1'b0;
    assign MD_Start = 1'b0;
    assign MD_Busy  = 1'b0;
    assign MD_Done  = 1'b0;
`endif

    assign stall = load_use || md_haz;

    // A taken branch squashes the ID instruction, so its stall is moot.
    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        if (EX_BranchTaken) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
        end else if (stall) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Stall and flush controller for the 5-stage MIPS pipeline, working from the ID side. It holds an instruction in ID when forwarding cannot supply its operand in time:
- a load-use dependency, or
- a read of an unfinished multi-cycle multiply/divide result.

It also squashes wrong-path instructions on a taken branch. Its outputs drive the PC write enable and the IF/ID and ID/EX pipeline registers.

## Interface
Parameters:
- MD_LATENCY, 32, number of cycles the multi-cycle mult/div unit stays busy after it starts (must be ≥2).
- CNT_W, 6, busy-counter width; must satisfy 2^CNT_W > MD_LATENCY.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- ID_Rs, ID_Rt  input  5 each  source registers of the instruction in ID.
- ID_UsesRs, ID_UsesRt  input  1 each  the ID instruction actually reads that source.
- ID_MulDiv  input  1  the ID instruction is mult/multu/div/divu.
- ID_ReadsHiLo  input  1  the ID instruction is mfhi/mflo.
- ID_EX_MemRead  input  1  the instruction in EX is a load.
- ID_EX_Rt  input  5  destination register of that load.
- EX_BranchTaken  input  1  a branch or jump resolved taken in EX.
- PCWrite  output  1  PC update enable.
- IF_ID_Write  output  1  IF/ID register write enable.
- IF_ID_Flush  output  1  clear IF/ID to a nop.
- ID_EX_Bubble  output  1  load zero control signals into ID/EX.
- MD_Start  output  1  one-cycle start strobe to the mult/div datapath.
- MD_Busy  output  1  registered; mult/div in progress.
- MD_Done  output  1  registered; one-cycle pulse when the result becomes valid.

## Operation
Combinational conditions:
- LoadUse = ID_EX_MemRead & ID_EX_Rt!=0 & ((ID_UsesRs & ID_Rs==ID_EX_Rt) | (ID_UsesRt & ID_Rt==ID_EX_Rt)).
- MDHaz = MD_Busy & (ID_MulDiv | ID_ReadsHiLo).
- Stall = LoadUse | MDHaz.

Priority of outputs:
1. If EX_BranchTaken: IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1, IF_ID_Write=1. Any stall is ignored, because the ID instruction is wrong-path.
2. Else if Stall: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0.
3. Else: PCWrite=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Bubble=0.

Start condition:
- MD_Start = ID_MulDiv & !Stall & !EX_BranchTaken.

State machine, states IDLE and BUSY:
- IDLE to BUSY on MD_Start; the counter loads MD_LATENCY-1.
- BUSY: the counter decrements each cycle.
- BUSY to IDLE on the edge where the counter is 0.
- MD_Busy = (state==BUSY).
- MD_Done is registered and is 1 for exactly the first cycle after BUSY exits.
- Register 0 never causes a load-use stall.

## Timing
- Reset: asserted value of every registered output and state:
  - state=IDLE, counter=0, MD_Busy=0, MD_Done=0.
  - Combinational outputs then settle to PCWrite=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Bubble=0, MD_Start=0.
- Load-use costs exactly 1 bubble. The next cycle the load is in MEM, so LoadUse is 0 and forwarding covers the operand.
- MD_Busy is high for exactly MD_LATENCY cycles, starting the cycle after MD_Start.
- A dependent mfhi/mflo or mult/div issues in the MD_Done cycle.
- A second ID_MulDiv while BUSY stalls; it does not restart the counter.
- Taken branch coinciding with a stall: the flush wins, and the stalled instruction is squashed without starting mult/div.
- Taken branch while BUSY: the in-flight operation continues, because it was issued before the branch.
- Reset mid-BUSY aborts the operation immediately: MD_Busy=0 and no MD_Done pulse.

## Configuration
- Macro HAZARD_MULDIV_EN.
- Defined: the FSM, counter, MD_Start, MD_Busy and MD_Done are implemented as above.
- Undefined:
  - no counter or state register;
  - MD_Start, MD_Busy and MD_Done are tied to 0, so MDHaz=0;
  - ID_MulDiv and ID_ReadsHiLo are ignored;
  - only load-use stalls and branch flushes remain.

## Test plan
- Load-use: ID_EX_MemRead=1, ID_EX_Rt=8, ID_Rs=8, ID_UsesRs=1 → that cycle PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1; the next cycle, with ID_EX_MemRead=0, all return to normal.
- Zero register and unused source:
  - ID_EX_Rt=0 with ID_Rs=0 → no stall;
  - ID_EX_Rt=9, ID_Rt=9, ID_UsesRt=0 → no stall.
- Mult/div with MD_LATENCY=4: ID_MulDiv=1 → MD_Start for 1 cycle, then MD_Busy=1 for 4 cycles. An mfhi in ID during busy stalls each cycle, and is released in the cycle MD_Done=1.
- Branch over stall: EX_BranchTaken=1 while LoadUse=1 and ID_MulDiv=1 → IF_ID_Flush=1, ID_EX_Bubble=1, PCWrite=1, MD_Start=0.
- Reset mid-operation: rst driven low on the 2nd BUSY cycle → MD_Busy=0 asynchronously; no MD_Done after release; the next ID_MulDiv restarts a full 4-cycle busy.
- Build without HAZARD_MULDIV_EN: ID_MulDiv=1 followed by mflo → no stalls, and MD_Busy stays 0.
